booth_multiplier: RTL and testbench

Sequential signed two's-complement multiplier using the radix-2 Booth algorithm. It feeds `ripple_carry_adder` as its add/subtract datapath: the block instantiates one `ripple_carry_adder` and drives its `add_sub_b`, `in1` and `in2` from its own state machine. It consumes the adder's `out` each iteration and produces a 2*BUS_WIDTH-bit product after BUS_WIDTH iterations. It sits in the arithmetic unit alongside the adder and serves multiply operations that tolerate multi-cycle latency.

---
 rtl/booth_multiplier.sv | 136 +++++++++++++
 tb/tb_booth_multiplier.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/booth_multiplier.sv
// booth_multiplier: sequential signed radix-2 Booth multiplier.
//   clk   - rising-edge clock
//   rst   - asynchronous active-high reset
//   start - request, sampled only when idle
//   in1   - signed multiplicand (captured on the accepting edge)
//   in2   - signed multiplier (captured on the accepting edge)
//   busy  - high while calculating or presenting done
//   done  - one-cycle pulse when out is updated
//   out   - signed 2*BUS_WIDTH-bit product, holds the last result
// ripple_carry_adder: add/subtract datapath used once per iteration.
//   add_sub_b - 1: in1+in2, 0: in1-in2
//   in1, in2  - operands
//   out       - result
//   ovf       - signed overflow

module ripple_carry_adder #(
  parameter int BUS_WIDTH = 32
) (
  input  logic                 add_sub_b,
  input  logic [BUS_WIDTH-1:0] in1,
  input  logic [BUS_WIDTH-1:0] in2,
  output logic [BUS_WIDTH-1:0] out,
  output logic                 ovf
);

  logic [BUS_WIDTH-1:0] b_eff;
  logic [BUS_WIDTH:0]   carry;

  always_comb begin
    // Subtraction as in1 + ~in2 + 1
    b_eff    = in2 ^ {BUS_WIDTH{~add_sub_b}};
    carry    = '0;
    carry[0] = ~add_sub_b;
    out      = '0;
    for (int unsigned i = 0; i < BUS_WIDTH; i++) begin
      out[i]     = in1[i] ^ b_eff[i] ^ carry[i];
      carry[i+1] = (in1[i] & b_eff[i]) | (carry[i] & (in1[i] ^ b_eff[i]));
    end
    ovf = carry[BUS_WIDTH] ^ carry[BUS_WIDTH-1];
  end

endmodule

module booth_multiplier #(
  parameter int BUS_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [BUS_WIDTH-1:0]   in1,
  input  logic [BUS_WIDTH-1:0]   in2,
  output logic                   busy,
  output logic                   done,
  output logic [2*BUS_WIDTH-1:0] out
);

  localparam int CW = $clog2(BUS_WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(BUS_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t               state;
  logic [BUS_WIDTH:0]   a;
  logic [BUS_WIDTH:0]   m;
  logic [BUS_WIDTH-1:0] q;
  logic                 q_1;
  logic [CW-1:0]        count;
  logic [BUS_WIDTH:0]   sum;
  logic [BUS_WIDTH:0]   s;

  // For decode 01 q_1=1 selects add, for 10 q_1=0 selects subtract;
  // for 00/11 the adder result is discarded, so q_1 drives the mode directly.
  ripple_carry_adder #(.BUS_WIDTH(BUS_WIDTH + 1)) u_adder (
    .add_sub_b (q_1),
    .in1       (a),
    .in2       (m),
    .out       (sum),
    .ovf       ()
  );

  always_comb begin
    s = a;
    if (q[0] ^ q_1) s = sum;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      out   <= '0;
      a     <= '0;
      m     <= '0;
      q     <= '0;
      q_1   <= 1'b0;
      count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            m     <= {in1[BUS_WIDTH-1], in1};
            a     <= '0;
            q     <= in2;
            q_1   <= 1'b0;
            count <= '0;
            busy  <= 1'b1;
            state <= CALC;
          end
        end
        CALC: begin
          a     <= {s[BUS_WIDTH], s[BUS_WIDTH:1]};
          q     <= {s[0], q[BUS_WIDTH-1:1]};
          q_1   <= q[0];
          count <= count + CW'(1);
          if (count == LAST) begin
            // Post-shift {A[BW-1:0], Q} equals {S, Q[BW-1:1]}
            out   <= {s, q[BUS_WIDTH-1:1]};
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_multiplier.sv
// Self-checking bench for booth_multiplier (BUS_WIDTH = 32).
module tb_booth_multiplier;

  localparam int BW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [BW-1:0] in1;
  logic [BW-1:0] in2;
  logic          busy;
  logic          done;
  logic [2*BW-1:0] out;

  int errors = 0;
  int checks = 0;
  int edge_cnt = 0;

  booth_multiplier #(.BUS_WIDTH(BW)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .in1   (in1),
    .in2   (in2),
    .busy  (busy),
    .done  (done),
    .out   (out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_mul(input logic [BW-1:0] x, input logic [BW-1:0] y);
    longint sx;
    longint sy;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    return 64'(sx * sy);
  endfunction

  // One operation from idle: checks latency, busy width, single done pulse, product.
  task automatic do_op(input string tag, input logic [BW-1:0] x, input logic [BW-1:0] y,
                       input logic [63:0] exp);
    int cyc;
    int busy_cycles;
    @(negedge clk);
    in1 = x; in2 = y; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    in1 = $urandom; in2 = $urandom;
    busy_cycles = busy ? 1 : 0;
    check({tag, "_done_early"}, 64'(done), 64'd0);
    cyc = 0;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (busy) busy_cycles++;
    end
    check({tag, "_latency"}, 64'(cyc), 64'd32);
    check({tag, "_out"}, out, exp);
    @(negedge clk);
    check({tag, "_done_width"}, 64'(done), 64'd0);
    check({tag, "_busy_cycles"}, 64'(busy_cycles), 64'd33);
    check({tag, "_busy_off"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int dones;
    int cyc;
    int last_done;
    logic [BW-1:0] x;
    logic [BW-1:0] y;

    rst = 1'b1; start = 1'b0; in1 = '0; in2 = '0;
    #12;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_out", out, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    do_op("basic", 32'd6, 32'd7, 64'd42);
    do_op("neg_pos", 32'hFFFF_FFFD, 32'd5, 64'hFFFF_FFFF_FFFF_FFF1);
    do_op("neg_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd1);
    do_op("min_min", 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
    do_op("min_one", 32'h8000_0000, 32'd1, 64'hFFFF_FFFF_8000_0000);
    do_op("max_max", 32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001);

    // Start pulses while busy (edge k+5 and the DONE edge k+32) are ignored
    @(negedge clk);
    in1 = 32'd6; in2 = 32'd7; start = 1'b1;
    @(posedge clk);
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) dones++;
      start = (i == 4 || i == 31);
      in1 = 32'd9; in2 = 32'd9;
    end
    start = 1'b0;
    check("busy_start_dones", 64'(dones), 64'd1);
    check("busy_start_out", out, 64'd42);
    check("busy_start_idle", 64'(busy), 64'd0);
    do_op("after_ignored", 32'd9, 32'd9, 64'd81);

    // Asynchronous reset mid-operation
    @(negedge clk);
    in1 = 32'd6; in2 = 32'd7; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_out", out, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done || busy) dones++;
    end
    check("abort_no_done", 64'(dones), 64'd0);
    do_op("after_abort", 32'd2, 32'd3, 64'd6);

    // Continuous start, new random operands presented in each idle cycle
    @(negedge clk);
    start = 1'b1;
    last_done = 0;
    for (int i = 0; i < 200; i++) begin
      x = $urandom; y = $urandom;
      in1 = x; in2 = y;
      @(negedge clk);
      in1 = $urandom; in2 = $urandom;
      cyc = 0;
      while (!done && cyc < 40) begin
        @(negedge clk);
        cyc++;
      end
      check("cont_out", out, ref_mul(x, y));
      if (i > 0) check("cont_spacing", 64'(edge_cnt - last_done), 64'd34);
      last_done = edge_cnt;
      @(negedge clk);
      check("cont_idle", 64'(busy), 64'd0);
    end
    start = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
